// File: rtl/regfile.sv
// 8 x 16-bit CPU register file. Two combinational read ports and one
// synchronous write port, with an optional write-to-read bypass.
module regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] rega,
  input  logic [ADDR_W-1:0] regb,
  input  logic [ADDR_W-1:0] wreg,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // NOTE: the array is cleared on reset, so it maps to flops rather than a
  // RAM macro; each entry is written through its own decoded enable so an
  // unknown wreg matches no entry and leaves every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wreg == ADDR_W'(i)) regs[i] <= writedata;
      end
    end
  end

  logic bypass_on;
  assign bypass_on = (BYPASS != 0) && write_en && !rst;

  // NOTE: every output gets its default before the bypass override, so the
  // read mux never infers a latch.
  always_comb begin
    read1 = regs[rega];
    read2 = regs[regb];
    if (bypass_on && (rega == wreg)) read1 = writedata;
    if (bypass_on && (regb == wreg)) read2 = writedata;
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a directed vector table, hand-written
// corner sequences and random traffic against an array-based model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst, write_en;
  logic [2:0]  rega, regb, wreg;
  logic [15:0] writedata;
  logic [15:0] read1, read2, read1_b, read2_b;

  int checks = 0;
  int failures = 0;

  logic [15:0] mdl [8];

  regfile #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .rega(rega), .regb(regb),
    .wreg(wreg), .writedata(writedata), .read1(read1), .read2(read2)
  );

  regfile #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .write_en(write_en), .rega(rega), .regb(regb),
    .wreg(wreg), .writedata(writedata), .read1(read1_b), .read2(read2_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  ra, rb, wr;
    logic [15:0] wd;
    logic [15:0] e1, e2;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the architectural rules: stored contents, or
  // the incoming data when bypass is enabled and the port hits the write.
  function automatic logic [15:0] exp_rd(input bit byp, input logic [2:0] a);
    if (byp && write_en && !rst && a == wreg) return writedata;
    return mdl[a];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] wr, input logic [15:0] wd);
    @(negedge clk);
    rst = r; write_en = we; rega = ra; regb = rb; wreg = wr; writedata = wd;
    #2;
  endtask

  task automatic check_model();
    check("r1_model",     read1,   exp_rd(1'b0, rega));
    check("r2_model",     read2,   exp_rd(1'b0, regb));
    check("r1_byp_model", read1_b, exp_rd(1'b1, rega));
    check("r2_byp_model", read2_b, exp_rd(1'b1, regb));
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    end else if (write_en) begin
      mdl[wreg] = writedata;
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] wr, input logic [15:0] wd);
    drive(r, we, ra, rb, wr, wd);
    check_model();
    commit();
  endtask

  vec_t vecs [10];

  initial begin
    rst = 1'b1; write_en = 1'b0; rega = '0; regb = '0; wreg = '0; writedata = '0;

    // Two reset edges from the undefined power-up state.
    drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000);
    commit();
    drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000);
    commit();

    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 3'(a), 3'(7 - a), 3'd0, 16'h0000);
      check("reset_r1", read1, 16'h0000);
      check("reset_r2", read2, 16'h0000);
      check_model();
      commit();
    end

    // All registers written with a distinct pattern, then read on both ports.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd0, 3'd0, 3'(i), 16'hA5A0 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'(i), 3'(i), 3'd0, 16'h0000);
      check("all_r1", read1, 16'hA5A0 + 16'(i));
      check("all_r2", read2, 16'hA5A0 + 16'(i));
      commit();
    end

    // {rst, we, ra, rb, wr, wd, read1 before edge, read2 before edge} for BYPASS=0.
    vecs[0] = '{1'b0, 1'b1, 3'd6, 3'd7, 3'd7, 16'hFFFF, 16'hA5A6, 16'hA5A7};
    vecs[1] = '{1'b0, 1'b0, 3'd7, 3'd6, 3'd3, 16'h1234, 16'hFFFF, 16'hA5A6};
    vecs[2] = '{1'b0, 1'b0, 3'd3, 3'd3, 3'd3, 16'h1234, 16'hA5A3, 16'hA5A3};
    vecs[3] = '{1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 16'hBEEF, 16'hA5A2, 16'hA5A2};
    vecs[4] = '{1'b0, 1'b0, 3'd2, 3'd7, 3'd2, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 3'd0, 3'd1, 3'd1, 16'h0001, 16'h0000, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 3'd1, 3'd0, 3'd4, 16'h0011, 16'h0001, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 3'd4, 3'd4, 3'd4, 16'h2222, 16'h0011, 16'h0011};
    vecs[8] = '{1'b0, 1'b0, 3'd4, 3'd4, 3'd0, 16'h0000, 16'h2222, 16'h2222};
    vecs[9] = '{1'b0, 1'b1, 3'd4, 3'd1, 3'd5, 16'h5555, 16'h2222, 16'h0001};

    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].ra, vecs[v].rb, vecs[v].wr, vecs[v].wd);
      check("vec_r1", read1, vecs[v].e1);
      check("vec_r2", read2, vecs[v].e2);
      check_model();
      commit();
    end

    // Read-during-write with bypass: new data visible before the edge.
    drive(1'b0, 1'b1, 3'd4, 3'd4, 3'd4, 16'h3333);
    check("rdw_byp_r1", read1_b, 16'h3333);
    check("rdw_byp_r2", read2_b, 16'h3333);
    check("rdw_nobyp_r1", read1, 16'h2222);
    commit();
    drive(1'b0, 1'b0, 3'd4, 3'd4, 3'd0, 16'h0000);
    check("rdw_after_r1", read1, 16'h3333);
    check("rdw_after_r2", read2_b, 16'h3333);

    // Address change with the clock held low propagates immediately.
    rega = 3'd0;
    #1;
    check("comb_r1_a0", read1, 16'h0000);
    rega = 3'd5;
    #1;
    check("comb_r1_a5", read1, 16'h5555);
    commit();

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] wd;
      wd = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom), 3'($urandom),
           3'($urandom), wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
